multicycle_ctrl: RTL

Main control FSM that sequences a multicycle MIPS-subset datapath sharing one ALU and one unified memory port. It decodes opcode/funct from the instruction register and drives per-state datapath selects, write enables and ALU control. Each memory access uses a req/ready handshake of variable latency. The block also counts retired instructions and halts on illegal encodings.

---
 rtl/multicycle_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl
//  Brief    : Main control FSM for a multicycle MIPS-subset datapath with a
//             shared ALU and a unified req/ready memory port. Counts retired
//             instructions and parks in HALT on illegal encodings.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             i_or_d,
   output logic             mem_write,
   output logic             ir_write,
   output logic             pc_write,
   output logic             branch,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alucontrol,
   output logic [1:0]       pc_src,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11,
      S_HALT   = 4'd12
   } state_t;

   localparam logic [5:0] c_OP_RTYPE = 6'b000000;
   localparam logic [5:0] c_OP_LW    = 6'b100011;
   localparam logic [5:0] c_OP_SW    = 6'b101011;
   localparam logic [5:0] c_OP_BEQ   = 6'b000100;
   localparam logic [5:0] c_OP_ADDI  = 6'b001000;
   localparam logic [5:0] c_OP_J     = 6'b000010;

   localparam logic [5:0] c_FN_ADD = 6'b100000;
   localparam logic [5:0] c_FN_SUB = 6'b100010;
   localparam logic [5:0] c_FN_AND = 6'b100100;
   localparam logic [5:0] c_FN_OR  = 6'b100101;
   localparam logic [5:0] c_FN_SLT = 6'b101010;

   localparam logic [2:0] c_ALU_ADD = 3'b010;
   localparam logic [2:0] c_ALU_SUB = 3'b110;
   localparam logic [2:0] c_ALU_AND = 3'b000;
   localparam logic [2:0] c_ALU_OR  = 3'b001;
   localparam logic [2:0] c_ALU_SLT = 3'b111;

   state_t           r_state;
   state_t           w_next;
   logic             w_mem_req;
   logic             w_ir_write;
   logic             w_pc_write;
   logic             w_funct_legal;
   logic             w_retire;
   logic [CNT_W-1:0] r_retired;

   // R-type instructions are only accepted for the five supported functs
   always_comb begin
      w_funct_legal = (funct == c_FN_ADD) || (funct == c_FN_SUB) ||
                      (funct == c_FN_AND) || (funct == c_FN_OR)  ||
                      (funct == c_FN_SLT);
   end

   // State register; reset always restarts at instruction fetch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   // Next-state decode and per-state datapath controls
   always_comb begin
      w_next     = r_state;
      w_mem_req  = 1'b0;
      i_or_d     = 1'b0;
      mem_write  = 1'b0;
      w_ir_write = 1'b0;
      w_pc_write = 1'b0;
      branch     = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alucontrol = 3'b000;
      pc_src     = 2'b00;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      halted     = 1'b0;
      w_retire   = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mem_req  = 1'b1;
            alu_src_b  = 2'b01;
            alucontrol = c_ALU_ADD;
            w_ir_write = mem_ready;
            w_pc_write = mem_ready;
            if (mem_ready) w_next = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b  = 2'b11;
            alucontrol = c_ALU_ADD;
            if ((opcode == c_OP_LW) || (opcode == c_OP_SW))       w_next = S_MEMADR;
            else if ((opcode == c_OP_RTYPE) && w_funct_legal)     w_next = S_EXEC;
            else if (opcode == c_OP_BEQ)                          w_next = S_BRANCH;
            else if (opcode == c_OP_ADDI)                         w_next = S_ADDIEX;
            else if (opcode == c_OP_J)                            w_next = S_JUMP;
            else                                                  w_next = S_HALT;
         end
         S_MEMADR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            alucontrol = c_ALU_ADD;
            w_next     = (opcode == c_OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            w_mem_req = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ready) w_next = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            w_retire   = 1'b1;
            w_next     = S_FETCH;
         end
         S_MEMWR: begin
            w_mem_req = 1'b1;
            i_or_d    = 1'b1;
            mem_write = 1'b1;
            if (mem_ready) begin
               w_retire = 1'b1;
               w_next   = S_FETCH;
            end
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            case (funct)
               c_FN_ADD: alucontrol = c_ALU_ADD;
               c_FN_SUB: alucontrol = c_ALU_SUB;
               c_FN_AND: alucontrol = c_ALU_AND;
               c_FN_OR:  alucontrol = c_ALU_OR;
               c_FN_SLT: alucontrol = c_ALU_SLT;
               default:  alucontrol = 3'b000;
            endcase
            w_next = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            w_retire  = 1'b1;
            w_next    = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a  = 1'b1;
            alucontrol = c_ALU_SUB;
            branch     = 1'b1;
            pc_src     = 2'b01;
            w_retire   = 1'b1;
            w_next     = S_FETCH;
         end
         S_ADDIEX: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            alucontrol = c_ALU_ADD;
            w_next     = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
            w_retire  = 1'b1;
            w_next    = S_FETCH;
         end
         S_JUMP: begin
            w_pc_write = 1'b1;
            pc_src     = 2'b10;
            w_retire   = 1'b1;
            w_next     = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            w_next = S_FETCH;
         end
      endcase
   end

   // Strobes that touch memory or architectural state are killed while in reset
   always_comb begin
      mem_req  = w_mem_req  & rst_n;
      ir_write = w_ir_write & rst_n;
      pc_write = w_pc_write & rst_n;
   end

   // Retired-instruction counter, wraps naturally at 2^CNT_W
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_retired <= '0;
      else if (w_retire) r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   assign retired = r_retired;

endmodule
`default_nettype wire
